// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_if : timing bundle produced by vga_sync_gen.
//   p_tick       one-clk pixel enable
//   pixel_x      current column (10 bit)
//   pixel_y      current line   (10 bit)
//   video_on     high inside the visible area
//   hsync/vsync  active-low sync pulses
//   frame_start  one-clk pulse when the position wraps to (0,0)
// master : the sync generator (drives everything)
// slave  : consumers such as the text generator and the connector pins
// ---------------------------------------------------------------------------
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );

  modport slave (
    input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen : 640x480@60 Hz VGA timing generator.
// Divides the system clock into a pixel enable and runs horizontal/vertical
// position counters. Sync, blanking and frame markers are all registered and
// decoded from the *next* position so they line up with pixel_x/pixel_y.
//
// Ports
//   clk    in   system clock (100 MHz)
//   reset  in   asynchronous, active-low reset
//   vga    vga_sync_if.master  (p_tick, pixel_x, pixel_y, video_on,
//                               hsync, vsync, frame_start)
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned HD       = 640,
  parameter int unsigned HF       = 16,
  parameter int unsigned HR       = 96,
  parameter int unsigned HB       = 48,
  parameter int unsigned VD       = 480,
  parameter int unsigned VF       = 10,
  parameter int unsigned VR       = 2,
  parameter int unsigned VB       = 33
) (
  input  logic        clk,
  input  logic        reset,
  vga_sync_if.master  vga
);

  localparam int unsigned H_TOTAL = HD + HF + HR + HB;
  localparam int unsigned V_TOTAL = VD + VF + VR + VB;
  localparam int unsigned DIV_W   = $clog2(TICK_DIV);

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(HD);
  localparam logic [9:0] V_VIS    = 10'(VD);
  localparam logic [9:0] HS_START = 10'(HD + HF);
  localparam logic [9:0] HS_END   = 10'(HD + HF + HR - 1);
  localparam logic [9:0] VS_START = 10'(VD + VF);
  localparam logic [9:0] VS_END   = 10'(VD + VF + VR - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_edge;
  logic [9:0]       x_q, y_q, x_nxt, y_nxt;
  logic             wrap_nxt;
  logic             hs_nxt, vs_nxt, von_nxt;
  logic             p_tick_q, hs_q, vs_q, von_q, fs_q;

  // The position advances on the same edge that raises p_tick.
  assign tick_edge = (div_cnt == DIV_MAX);

  // NOTE: every variable gets a default before any branch, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    x_nxt    = x_q;
    y_nxt    = y_q;
    wrap_nxt = 1'b0;
    if (tick_edge) begin
      if (x_q == H_MAX) begin
        x_nxt = '0;
        if (y_q == V_MAX) begin
          y_nxt    = '0;
          wrap_nxt = 1'b1;
        end else begin
          y_nxt = y_q + 10'd1;
        end
      end else begin
        x_nxt = x_q + 10'd1;
      end
    end
  end

  // Flags are decoded from the next position so the registered copies
  // describe the same pixel as the registered counters.
  always_comb begin
    hs_nxt  = !((x_nxt >= HS_START) && (x_nxt <= HS_END));
    vs_nxt  = !((y_nxt >= VS_START) && (y_nxt <= VS_END));
    von_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  // NOTE: non-blocking assignments for all state so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      p_tick_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= 1'b1;   // decode of (0,0)
      vs_q     <= 1'b1;
      von_q    <= 1'b1;
      fs_q     <= 1'b0;   // reset is not a frame wrap
    end else begin
      div_cnt  <= tick_edge ? '0 : div_cnt + DIV_W'(1);
      p_tick_q <= tick_edge;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      hs_q     <= hs_nxt;
      vs_q     <= vs_nxt;
      von_q    <= von_nxt;
      fs_q     <= wrap_nxt;
    end
  end

  assign vga.p_tick      = p_tick_q;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.video_on    = von_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen : bench for vga_sync_gen.
// Two instances share clk/reset: one with the standard 640x480 timing (line
// edges, horizontal wrap) and one with a shrunken frame (25x15 positions) so
// vertical sync, line VD blanking and frame wraps fit in a short run.
// Expected vectors are keyed by the p_tick count since reset release.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct {
    int tick;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit fs;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  exp_t big_q[$];
  exp_t small_q[$];

  int big_ticks   = 0;
  int small_ticks = 0;
  int vs_low_cnt  = 0;
  int fs_clk_cnt  = 0;

  vga_sync_if big_if ();
  vga_sync_if small_if ();

  vga_sync_gen u_big (
    .clk   (clk),
    .reset (reset),
    .vga   (big_if)
  );

  // 25 x 15 frame: visible 16x8, hsync x=18..20, vsync y=10..11, 375 ticks.
  vga_sync_gen #(
    .TICK_DIV (4),
    .HD (16), .HF (2), .HR (3), .HB (4),
    .VD (8),  .VF (2), .VR (2), .VB (3)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (small_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mk(input int tick, input int x, input int y,
                              input bit hs, input bit vs, input bit von,
                              input bit fs);
    exp_t e;
    e.tick = tick; e.x = x; e.y = y;
    e.hs = hs; e.vs = vs; e.von = von; e.fs = fs;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic hs, input logic vs,
                         input logic von, input logic fs);
    string n;
    n = $sformatf("%s_t%0d", tag, e.tick);
    check({n, "_x"},   32'(x),   32'(e.x));
    check({n, "_y"},   32'(y),   32'(e.y));
    check({n, "_hs"},  32'(hs),  32'(e.hs));
    check({n, "_vs"},  32'(vs),  32'(e.vs));
    check({n, "_von"}, 32'(von), 32'(e.von));
    check({n, "_fs"},  32'(fs),  32'(e.fs));
  endtask

  // Monitor: standard-timing instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      big_ticks = 0;
    end else if (big_if.p_tick) begin
      big_ticks++;
      while (big_q.size() > 0 && big_q[0].tick == big_ticks) begin
        e = big_q.pop_front();
        compare("big", e, big_if.pixel_x, big_if.pixel_y, big_if.hsync,
                big_if.vsync, big_if.video_on, big_if.frame_start);
      end
    end
  end

  // Monitor: shrunken-frame instance, plus per-frame vsync/frame_start tallies.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      small_ticks = 0;
      vs_low_cnt  = 0;
      fs_clk_cnt  = 0;
    end else begin
      if (small_if.frame_start) fs_clk_cnt++;
      if (small_if.p_tick) begin
        small_ticks++;
        if (!small_if.vsync) vs_low_cnt++;
        while (small_q.size() > 0 && small_q[0].tick == small_ticks) begin
          e = small_q.pop_front();
          compare("small", e, small_if.pixel_x, small_if.pixel_y, small_if.hsync,
                  small_if.vsync, small_if.video_on, small_if.frame_start);
        end
        if (small_ticks == 375) check("small_vsync_low_ticks_frame", 32'(vs_low_cnt), 32'd50);
        if (small_ticks == 750) check("small_frame_start_clks_2frames", 32'(fs_clk_cnt), 32'd2);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_p_tick"},   32'(big_if.p_tick),      32'd0);
    check({tag, "_x"},        32'(big_if.pixel_x),     32'd0);
    check({tag, "_y"},        32'(big_if.pixel_y),     32'd0);
    check({tag, "_hsync"},    32'(big_if.hsync),       32'd1);
    check({tag, "_vsync"},    32'(big_if.vsync),       32'd1);
    check({tag, "_video_on"}, 32'(big_if.video_on),    32'd1);
    check({tag, "_fs"},       32'(big_if.frame_start), 32'd0);
    check({tag, "_small_x"},  32'(small_if.pixel_x),   32'd0);
    check({tag, "_small_y"},  32'(small_if.pixel_y),   32'd0);
  endtask

  // Release at a negedge, then p_tick must be 0,0,0,1,0,0,0,1 on the
  // following negedges (first pulse after the 4th rising edge).
  task automatic release_and_check_cadence(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("%s_p_tick_clk%0d", tag, k), 32'(big_if.p_tick),
            (k % 4 == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((big_q.size() != 0 || small_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_queues_drained"}, 32'(big_q.size() + small_q.size()), 32'd0);
  endtask

  initial begin
    int n;

    // Standard timing: tick n lands on (n % 800, n / 800).
    big_q.push_back(mk(1,    1,   0,  1, 1, 1, 0));
    big_q.push_back(mk(639,  639, 0,  1, 1, 1, 0));
    big_q.push_back(mk(640,  640, 0,  1, 1, 0, 0));
    big_q.push_back(mk(655,  655, 0,  1, 1, 0, 0));
    big_q.push_back(mk(656,  656, 0,  0, 1, 0, 0));
    big_q.push_back(mk(751,  751, 0,  0, 1, 0, 0));
    big_q.push_back(mk(752,  752, 0,  1, 1, 0, 0));
    big_q.push_back(mk(799,  799, 0,  1, 1, 0, 0));
    big_q.push_back(mk(800,  0,   1,  1, 1, 1, 0));
    big_q.push_back(mk(8799, 799, 10, 1, 1, 0, 0));
    big_q.push_back(mk(8800, 0,   11, 1, 1, 1, 0));

    // Shrunken frame: tick n lands on (n % 25, (n / 25) % 15).
    small_q.push_back(mk(16,  16, 0,  1, 1, 0, 0));
    small_q.push_back(mk(18,  18, 0,  0, 1, 0, 0));
    small_q.push_back(mk(21,  21, 0,  1, 1, 0, 0));
    small_q.push_back(mk(200, 0,  8,  1, 1, 0, 0));
    small_q.push_back(mk(215, 15, 8,  1, 1, 0, 0));
    small_q.push_back(mk(250, 0,  10, 1, 0, 0, 0));
    small_q.push_back(mk(299, 24, 11, 1, 0, 0, 0));
    small_q.push_back(mk(300, 0,  12, 1, 1, 0, 0));
    small_q.push_back(mk(374, 24, 14, 1, 1, 0, 0));
    small_q.push_back(mk(375, 0,  0,  1, 1, 1, 1));
    small_q.push_back(mk(376, 1,  0,  1, 1, 1, 0));
    small_q.push_back(mk(750, 0,  0,  1, 1, 1, 1));

    // Power-on reset held for 3 clocks.
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("por");
    release_and_check_cadence("por");

    wait_drain("run1", 40000);

    // Reach x==300 and drop reset between clock edges.
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (big_if.pixel_x != 10'd300 && n < 5000);
    check("reach_x300", 32'(big_if.pixel_x), 32'd300);
    reset = 1'b0;
    #1;
    check_reset_values("async");
    repeat (3) @(posedge clk);

    big_q.push_back(mk(1,   1,   0, 1, 1, 1, 0));
    big_q.push_back(mk(656, 656, 0, 0, 1, 0, 0));
    big_q.push_back(mk(752, 752, 0, 1, 1, 0, 0));
    small_q.push_back(mk(18, 18, 0, 0, 1, 0, 0));
    release_and_check_cadence("rerun");
    wait_drain("run2", 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
